ice_brk_ctl: RTL and testbench

ICE_BRK_CTL -- requirements
Module: ice_brk_ctl

---
 rtl/ice_brk_ctl.sv | 153 +++++++++++++++
 tb/tb_ice_brk_ctl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ice_brk_ctl.sv
// ice_brk_ctl: in-circuit-emulator break/step controller.
// Halts the CPU on an address break or a forced stop request and lets the
// debugger resume it or single-step it a programmable number of bus cycles.
module ice_brk_ctl #(
    parameter int unsigned ADRW = 16,
    parameter int unsigned CNTW = 8
) (
    input  logic            CLK,
    input  logic            RESB,
    input  logic            CPUVALID,
    input  logic [ADRW-1:0] CPUADR,
    input  logic            CPUWR,
    input  logic            CPUPID1,
    input  logic            CPUPID0,
    input  logic            BRKEN,
    input  logic [ADRW-1:0] BRKADR,
    input  logic            BRKWRONLY,
    input  logic            STOPREQ,
    input  logic            GOREQ,
    input  logic            STEPREQ,
    input  logic [CNTW-1:0] STEPNUM,
    output logic            STPST,
    output logic            PID1,
    output logic            PID0,
    output logic            CPUHOLD,
    output logic            BRKHIT,
    output logic [CNTW-1:0] CYCCNT
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_STOP = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNTW-1:0] r_stepcnt;
    logic [CNTW-1:0] w_stepcnt_nxt;
    logic            w_match;
    logic            w_brk_take;
    logic            w_cpu_live;

    logic            r_stpst;
    logic            r_pid1;
    logic            r_pid0;
    logic            r_cpuhold;
    logic            r_brkhit;
    logic [CNTW-1:0] r_cyccnt;

    // Address comparator with optional write-only qualification
    assign w_match    = CPUVALID & BRKEN & (CPUADR == BRKADR) & (CPUWR | ~BRKWRONLY);
    // CPU is executing (not held) in RUN and STEP
    assign w_cpu_live = (r_state == ST_RUN) || (r_state == ST_STEP);

    // State and step-counter register
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_state   <= ST_RUN;
            r_stepcnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_stepcnt <= w_stepcnt_nxt;
        end
    end

    // Next-state, step-counter and break-taken decode
    always_comb begin
        w_state_nxt   = r_state;
        w_stepcnt_nxt = r_stepcnt;
        w_brk_take    = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_match || STOPREQ) begin
                    w_state_nxt = ST_PEND;
                    w_brk_take  = w_match;
                end
            end
            ST_PEND: begin
                w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (GOREQ) begin
                    w_state_nxt = ST_RUN;
                end else if (STEPREQ) begin
                    w_state_nxt   = ST_STEP;
                    w_stepcnt_nxt = (STEPNUM == '0) ? CNT_ONE : STEPNUM;
                end
            end
            ST_STEP: begin
                if (CPUVALID && (r_stepcnt != '0)) begin
                    w_stepcnt_nxt = r_stepcnt - CNT_ONE;
                end
                if (w_match || STOPREQ) begin
                    w_state_nxt = ST_PEND;
                    w_brk_take  = w_match;
                end else if (CPUVALID && (r_stepcnt <= CNT_ONE)) begin
                    w_state_nxt = ST_PEND;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Registered status, hold and break-pulse outputs from the next state
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_stpst   <= 1'b0;
            r_cpuhold <= 1'b0;
            r_brkhit  <= 1'b0;
        end else begin
            r_stpst   <= (w_state_nxt == ST_STOP);
            r_cpuhold <= (w_state_nxt == ST_PEND) || (w_state_nxt == ST_STOP);
            r_brkhit  <= w_brk_take;
        end
    end

    // Process ID tracks the CPU while it executes, frozen while held
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_pid1 <= 1'b0;
            r_pid0 <= 1'b0;
        end else if (w_cpu_live) begin
            r_pid1 <= CPUPID1;
            r_pid0 <= CPUPID0;
        end
    end

    // Saturating bus-cycle counter, cleared on resume
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_cyccnt <= '0;
        end else if ((r_state == ST_STOP) && GOREQ) begin
            r_cyccnt <= '0;
        end else if (w_cpu_live && CPUVALID && (r_cyccnt != CNT_MAX)) begin
            r_cyccnt <= r_cyccnt + CNT_ONE;
        end
    end

    assign STPST   = r_stpst;
    assign PID1    = r_pid1;
    assign PID0    = r_pid0;
    assign CPUHOLD = r_cpuhold;
    assign BRKHIT  = r_brkhit;
    assign CYCCNT  = r_cyccnt;

endmodule

// File: tb/tb_ice_brk_ctl.sv
// tb_ice_brk_ctl: directed scenarios plus random traffic checked against a
// flag-based behavioural model of the halt/step controller.
module tb_ice_brk_ctl;

    localparam int unsigned ADRW   = 16;
    localparam int unsigned CNTW   = 8;
    localparam int          CYCMAX = (1 << CNTW) - 1;

    logic            CLK = 1'b0;
    logic            RESB;
    logic            CPUVALID, CPUWR, CPUPID1, CPUPID0;
    logic [ADRW-1:0] CPUADR;
    logic            BRKEN, BRKWRONLY, STOPREQ, GOREQ, STEPREQ;
    logic [ADRW-1:0] BRKADR;
    logic [CNTW-1:0] STEPNUM;
    logic            STPST, PID1, PID0, CPUHOLD, BRKHIT;
    logic [CNTW-1:0] CYCCNT;

    ice_brk_ctl #(.ADRW(ADRW), .CNTW(CNTW)) dut (
        .CLK(CLK), .RESB(RESB), .CPUVALID(CPUVALID), .CPUADR(CPUADR),
        .CPUWR(CPUWR), .CPUPID1(CPUPID1), .CPUPID0(CPUPID0),
        .BRKEN(BRKEN), .BRKADR(BRKADR), .BRKWRONLY(BRKWRONLY),
        .STOPREQ(STOPREQ), .GOREQ(GOREQ), .STEPREQ(STEPREQ), .STEPNUM(STEPNUM),
        .STPST(STPST), .PID1(PID1), .PID0(PID0), .CPUHOLD(CPUHOLD),
        .BRKHIT(BRKHIT), .CYCCNT(CYCCNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: CPU is halted (m_held), in its one-clock halting slot (m_pend),
    // or executing; m_steps>0 means executing under a step budget.
    bit m_held, m_pend, m_brkhit, m_pid1, m_pid0;
    int m_steps, m_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_pend = 0; m_brkhit = 0; m_pid1 = 0; m_pid0 = 0;
        m_steps = 0; m_cyc = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic model_clock();
        bit hit;
        hit = CPUVALID && BRKEN && (CPUADR == BRKADR) && (CPUWR || !BRKWRONLY);
        m_brkhit = 0;
        if (m_pend) begin
            m_pend = 0;
            m_held = 1;
        end else if (m_held) begin
            if (GOREQ) begin
                m_held = 0; m_cyc = 0; m_steps = 0;
            end else if (STEPREQ) begin
                m_held  = 0;
                m_steps = (STEPNUM == 0) ? 1 : int'(STEPNUM);
            end
        end else begin
            m_pid1 = CPUPID1;
            m_pid0 = CPUPID0;
            if (CPUVALID && m_cyc < CYCMAX) m_cyc++;
            if (hit || STOPREQ || (m_steps == 1 && CPUVALID)) begin
                m_pend = 1; m_brkhit = hit; m_steps = 0;
            end else if (m_steps > 1 && CPUVALID) begin
                m_steps--;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".stpst"},   32'(STPST),   32'(m_held));
        chk({tag, ".cpuhold"}, 32'(CPUHOLD), 32'(m_held | m_pend));
        chk({tag, ".brkhit"},  32'(BRKHIT),  32'(m_brkhit));
        chk({tag, ".pid"},     32'({PID1, PID0}), 32'({m_pid1, m_pid0}));
        chk({tag, ".cyccnt"},  32'(CYCCNT),  32'(m_cyc));
    endtask

    // Drive one clock of inputs (called just after a falling edge)
    task automatic cyc(input string tag, input bit v, input logic [ADRW-1:0] a,
                       input bit w, input bit [1:0] p, input bit sr,
                       input bit g, input bit s, input logic [CNTW-1:0] sn);
        CPUVALID = v; CPUADR = a; CPUWR = w; {CPUPID1, CPUPID0} = p;
        STOPREQ = sr; GOREQ = g; STEPREQ = s; STEPNUM = sn;
        model_clock();
        @(posedge CLK);
        @(negedge CLK);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 16'h0000, 0, 2'b00, 0, 0, 0, 8'd0);
    endtask

    // Pulse reset mid-cycle and verify outputs clear immediately
    task automatic pulse_reset(input string tag);
        #2;
        RESB = 1'b0;
        GOREQ = 0; STEPREQ = 0; STOPREQ = 0; CPUVALID = 0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(negedge CLK);
        RESB = 1'b1;
        idle({tag, ".rel"});
    endtask

    logic [7:0] cyc_before;

    initial begin
        RESB = 1'b0;
        CPUVALID = 0; CPUADR = '0; CPUWR = 0; CPUPID1 = 0; CPUPID0 = 0;
        BRKEN = 0; BRKADR = 16'h1234; BRKWRONLY = 0;
        STOPREQ = 0; GOREQ = 0; STEPREQ = 0; STEPNUM = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        check_outputs("reset");
        RESB = 1'b1;
        idle("post_reset");

        // Address break on any cycle type
        BRKEN = 1; BRKWRONLY = 0;
        cyc("pre_brk", 1, 16'h1000, 0, 2'b01, 0, 0, 0, 8'd0);
        cyc("brk_n1", 1, 16'h1234, 0, 2'b10, 0, 0, 0, 8'd0);
        chk("brk_n1.brkhit_const", 32'(BRKHIT), 32'd1);
        chk("brk_n1.hold_const", 32'(CPUHOLD), 32'd1);
        cyc("brk_n2", 1, 16'h0000, 0, 2'b01, 0, 0, 0, 8'd0);
        chk("brk_n2.stpst_const", 32'(STPST), 32'd1);
        chk("brk_n2.pid_frozen", 32'({PID1, PID0}), 32'd2);
        cyc("go1", 0, 16'h0000, 0, 2'b00, 0, 1, 0, 8'd0);

        // Write-only filter
        BRKWRONLY = 1;
        cyc("wo_rd", 1, 16'h1234, 0, 2'b11, 0, 0, 0, 8'd0);
        chk("wo_rd.nobrk", 32'(BRKHIT), 32'd0);
        cyc("wo_wr", 1, 16'h1234, 1, 2'b11, 0, 0, 0, 8'd0);
        chk("wo_wr.brk", 32'(BRKHIT), 32'd1);
        idle("wo_pend");

        // Step of 3 bus cycles
        cyc_before = CYCCNT;
        cyc("step3_req", 0, 16'h0000, 0, 2'b00, 0, 0, 1, 8'd3);
        for (int i = 0; i < 3; i++) cyc("step3_v", 1, 16'h2000, 0, 2'(i), 0, 0, 0, 8'd0);
        chk("step3.hold", 32'(CPUHOLD), 32'd1);
        idle("step3_stop");
        chk("step3.stpst", 32'(STPST), 32'd1);
        chk("step3.cyc_plus3", 32'(CYCCNT), 32'(cyc_before + 8'd3));

        // STEPNUM of 0 executes a single bus cycle
        cyc("step0_req", 0, 16'h0000, 0, 2'b00, 0, 0, 1, 8'd0);
        cyc("step0_v", 1, 16'h2000, 0, 2'b00, 0, 0, 0, 8'd0);
        chk("step0.hold", 32'(CPUHOLD), 32'd1);
        idle("step0_stop");

        // GO wins over STEP; then saturate the cycle counter
        cyc("go_step", 0, 16'h0000, 0, 2'b00, 0, 1, 1, 8'd4);
        chk("go_step.cyc_clr", 32'(CYCCNT), 32'd0);
        BRKEN = 0;
        for (int i = 0; i < 300; i++) cyc("sat", 1, 16'h1234, 1, 2'b00, 0, 0, 0, 8'd0);
        chk("sat.max", 32'(CYCCNT), 32'd255);

        // Reset mid-STEP with counter at 2
        cyc("rs_stop", 0, 16'h0000, 0, 2'b00, 1, 0, 0, 8'd0);
        cyc("rs_hold", 0, 16'h0000, 0, 2'b00, 1, 0, 0, 8'd0);
        cyc("rs_step", 0, 16'h0000, 0, 2'b00, 0, 0, 1, 8'd3);
        cyc("rs_v1", 1, 16'h3000, 0, 2'b01, 0, 0, 0, 8'd0);
        pulse_reset("rs_step");

        // Random traffic
        BRKADR = 16'h00A5;
        for (int i = 0; i < 2000; i++) begin
            bit sr;
            if (i % 97 == 0) begin
                BRKEN     = 1'($urandom_range(0, 3) != 0);
                BRKWRONLY = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                sr = ($urandom_range(0, 19) == 0);
                cyc("rnd", 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? 16'h00A5 : 16'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), sr,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                    8'($urandom_range(0, 4)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
